taus_sampler: RTL and testbench

Downstream consumer of the three free-running Tausworthe component stages. It XORs the component words into one 32-bit uniform sample and discards a programmable warm-up period after reset. It decimates the stream and buffers the accepted samples in a small show-ahead FIFO with a valid/ready output. The generators never stall: samples arriving while the FIFO is full are dropped.

---
 rtl/taus_sampler_if.sv | 24 ++
 rtl/taus_sampler.sv | 99 +++++++++
 tb/tb_taus_sampler.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/taus_sampler_if.sv
// Stream-side bundle of taus_sampler: three component words in, buffered
// uniform samples out with valid/ready, plus occupancy and warm-up status.
interface taus_sampler_if #(
    parameter int AW = 3
) ();
    logic        en;
    logic [31:0] taus0;
    logic [31:0] taus1;
    logic [31:0] taus2;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [AW:0] level;
    logic        warm_done;

    modport master (
        output en, taus0, taus1, taus2, out_ready,
        input  out_data, out_valid, level, warm_done
    );
    modport slave (
        input  en, taus0, taus1, taus2, out_ready,
        output out_data, out_valid, level, warm_done
    );
endinterface

// File: rtl/taus_sampler.sv
// Combines three Tausworthe component words, skips a warm-up period, decimates,
// and buffers samples in a show-ahead FIFO. Optional drop counter: TAUS_SAMPLER_STATS_EN.
module taus_sampler #(
    parameter int WARMUP = 16,
    parameter int DECIM  = 1,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    taus_sampler_if.slave bus
`ifdef TAUS_SAMPLER_STATS_EN
    , output logic [15:0] drop_cnt
`endif
);
    localparam logic [0:0]  ST_WARM  = 1'b0;
    localparam logic [0:0]  ST_RUN   = 1'b1;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [0:0]    state;
    logic [15:0]   warm_cnt;
    logic [7:0]    dec_cnt;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   comb;
    logic          run;
    logic          cap;
    logic          pop;
    logic          push;

    assign comb = bus.taus0 ^ bus.taus1 ^ bus.taus2;
    // With no warm-up the first cycle out of reset already samples, so the
    // registered state is bypassed; warm_done still follows the state register.
    assign run  = (state == ST_RUN) || (WARMUP == 0);
    assign cap  = run && bus.en && (dec_cnt == 8'd0);
    assign pop  = (count != '0) && bus.out_ready;
    assign push = cap && ((count != FULL_LVL) || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_WARM;
            warm_cnt <= '0;
        end else if (state == ST_WARM) begin
            if (WARMUP == 0) begin
                state <= ST_RUN;
            end else if (bus.en) begin
                warm_cnt <= warm_cnt + 16'd1;
                if (warm_cnt == 16'(WARMUP - 1))
                    state <= ST_RUN;
            end
        end
    end

    // Advances on every enabled RUN cycle, whether or not the capture is stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dec_cnt <= '0;
        else if (run && bus.en)
            dec_cnt <= (dec_cnt == 8'(DECIM - 1)) ? 8'd0 : dec_cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= comb;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef TAUS_SAMPLER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt <= '0;
        else if (cap && !push && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 16'd1;
    end
`endif

    assign bus.out_data  = mem[rd_ptr];
    assign bus.out_valid = (count != '0);
    assign bus.level     = count;
    assign bus.warm_done = (state == ST_RUN);
endmodule

// File: tb/tb_taus_sampler.sv
// Bench for taus_sampler: two instances (WARMUP=4/DECIM=1 and WARMUP=0/DECIM=3),
// a queue-style reference model per instance, directed tables and random traffic.
module tb_taus_sampler;
    logic clk   = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    int   total = 0;
    int   bad   = 0;
    bit   mon_on = 1'b0;

    localparam int MDEPTH = 8;

    always #5 clk = ~clk;

    taus_sampler_if #(.AW(3)) ia ();
    taus_sampler_if #(.AW(3)) ib ();

`ifdef TAUS_SAMPLER_STATS_EN
    logic [15:0] drop_a;
    logic [15:0] drop_b;
`endif

    taus_sampler #(.WARMUP(4), .DECIM(1), .DEPTH(8), .AW(3)) dut_a (
        .clk   (clk),
        .rst_n (rst_a),
        .bus   (ia)
`ifdef TAUS_SAMPLER_STATS_EN
        , .drop_cnt (drop_a)
`endif
    );

    taus_sampler #(.WARMUP(0), .DECIM(3), .DEPTH(8), .AW(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_b),
        .bus   (ib)
`ifdef TAUS_SAMPLER_STATS_EN
        , .drop_cnt (drop_b)
`endif
    );

    // Reference model: counts of edges / enabled cycles since reset and a circular word buffer.
    longint      m_edges [2];
    longint      m_en    [2];
    longint      m_run   [2];
    longint      m_drops [2];
    int          m_head  [2];
    int          m_cnt   [2];
    logic [31:0] m_mem   [2][64];

    function automatic int wu(input int i);
        return (i == 0) ? 4 : 0;
    endfunction

    function automatic int dc(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset(input int i);
        m_edges[i] = 0;
        m_en[i]    = 0;
        m_run[i]   = 0;
        m_drops[i] = 0;
        m_head[i]  = 0;
        m_cnt[i]   = 0;
    endtask

    task automatic model_step(input int i, input logic en, input logic rdy, input logic [31:0] w);
        bit run;
        bit cap;
        run = (wu(i) == 0) || (m_en[i] >= longint'(wu(i)));
        cap = run && en && ((m_run[i] % dc(i)) == 0);
        if (run && en) m_run[i]++;
        if (en) m_en[i]++;
        m_edges[i]++;
        if (m_cnt[i] > 0 && rdy) begin
            m_head[i] = (m_head[i] + 1) % 64;
            m_cnt[i]--;
        end
        if (cap) begin
            if (m_cnt[i] < MDEPTH) begin
                m_mem[i][(m_head[i] + m_cnt[i]) % 64] = w;
                m_cnt[i]++;
            end else begin
                m_drops[i]++;
            end
        end
    endtask

    task automatic check_model(input int i, input logic v, input logic [3:0] lv,
                               input logic [31:0] d, input logic wd);
        bit exp_warm;
        exp_warm = (wu(i) == 0) ? (m_edges[i] >= 1) : (m_en[i] >= longint'(wu(i)));
        chk($sformatf("mdl%0d.valid", i), 32'(v), 32'(m_cnt[i] > 0));
        chk($sformatf("mdl%0d.level", i), 32'(lv), 32'(m_cnt[i]));
        chk($sformatf("mdl%0d.warm", i), 32'(wd), 32'(exp_warm));
        if (m_cnt[i] > 0)
            chk($sformatf("mdl%0d.data", i), d, m_mem[i][m_head[i]]);
    endtask

    always @(posedge clk or negedge rst_a)
        if (!rst_a) model_reset(0);
        else        model_step(0, ia.en, ia.out_ready, ia.taus0 ^ ia.taus1 ^ ia.taus2);

    always @(posedge clk or negedge rst_b)
        if (!rst_b) model_reset(1);
        else        model_step(1, ib.en, ib.out_ready, ib.taus0 ^ ib.taus1 ^ ib.taus2);

    always @(negedge clk) begin
        if (mon_on) begin
            check_model(0, ia.out_valid, ia.level, ia.out_data, ia.warm_done);
            check_model(1, ib.out_valid, ib.level, ib.out_data, ib.warm_done);
`ifdef TAUS_SAMPLER_STATS_EN
            chk("mdl0.drop", 32'(drop_a), 32'((m_drops[0] > 65535) ? 65535 : m_drops[0]));
            chk("mdl1.drop", 32'(drop_b), 32'((m_drops[1] > 65535) ? 65535 : m_drops[1]));
`endif
        end
    end

    typedef struct {
        logic        en;
        logic        rdy;
        logic        warm;
        logic        valid;
        logic [3:0]  lvl;
        logic [31:0] data;
    } vec_t;

    vec_t        tab [8];
    bit          pat [20] = '{1,1,1,1,0,0,1,1,1,0,1,1,1,1,1,1,1,0,1,1};
    logic [31:0] got [$];

    initial begin
        int idx;
        logic [31:0] exp_w;

        // Row r describes the cycle ending at edge r+1 after reset release.
        tab[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0};
        tab[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0};
        tab[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0};
        tab[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0};
        tab[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd1, 32'h7};
        tab[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd1, 32'h7};
        tab[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0};
        tab[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd1, 32'h7};

        ia.en = 1'b0; ia.taus0 = '0; ia.taus1 = '0; ia.taus2 = '0; ia.out_ready = 1'b0;
        ib.en = 1'b0; ib.taus0 = '0; ib.taus1 = '0; ib.taus2 = '0; ib.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        mon_on = 1'b1;

        chk("rst.valid", 32'(ia.out_valid), 32'd0);
        chk("rst.level", 32'(ia.level), 32'd0);
        chk("rst.warm",  32'(ia.warm_done), 32'd0);
        chk("rst.data",  ia.out_data, 32'd0);
`ifdef TAUS_SAMPLER_STATS_EN
        chk("rst.drop", 32'(drop_a), 32'd0);
`endif

        // Warm-up table, constant 1/2/4 inputs
        ia.taus0 = 32'h1; ia.taus1 = 32'h2; ia.taus2 = 32'h4;
        rst_a = 1'b1;
        for (int r = 0; r < 8; r++) begin
            ia.en = tab[r].en;
            ia.out_ready = tab[r].rdy;
            @(negedge clk);
            chk($sformatf("warm.e%0d.warm_done", r + 1), 32'(ia.warm_done), 32'(tab[r].warm));
            chk($sformatf("warm.e%0d.valid", r + 1), 32'(ia.out_valid), 32'(tab[r].valid));
            chk($sformatf("warm.e%0d.level", r + 1), 32'(ia.level), 32'(tab[r].lvl));
            if (tab[r].valid)
                chk($sformatf("warm.e%0d.data", r + 1), ia.out_data, tab[r].data);
        end

        // Full / drop: 12 captures into an 8-deep FIFO with no consumer
        ia.en = 1'b0; ia.out_ready = 1'b1;
        @(negedge clk);
        chk("full.pre_level", 32'(ia.level), 32'd0);
        ia.out_ready = 1'b0; ia.taus1 = '0; ia.taus2 = '0;
        for (int k = 0; k < 12; k++) begin
            ia.en = 1'b1;
            ia.taus0 = 32'(100 + k);
            @(negedge clk);
        end
        chk("full.level", 32'(ia.level), 32'd8);
        chk("full.valid", 32'(ia.out_valid), 32'd1);
        chk("full.head",  ia.out_data, 32'd100);
`ifdef TAUS_SAMPLER_STATS_EN
        chk("full.drop", 32'(drop_a), 32'd4);
`endif

        // Full with simultaneous push and pop
        ia.taus0 = 32'd200; ia.out_ready = 1'b1;
        @(negedge clk);
        chk("pp.level", 32'(ia.level), 32'd8);
        chk("pp.head",  ia.out_data, 32'd101);
`ifdef TAUS_SAMPLER_STATS_EN
        chk("pp.drop", 32'(drop_a), 32'd4);
`endif
        ia.en = 1'b0;
        for (int j = 0; j < 8; j++) begin
            exp_w = (j < 7) ? 32'(101 + j) : 32'd200;
            chk($sformatf("drain%0d.valid", j), 32'(ia.out_valid), 32'd1);
            chk($sformatf("drain%0d.data", j), ia.out_data, exp_w);
            @(negedge clk);
        end
        chk("drain.empty", 32'(ia.out_valid), 32'd0);

        // Reset mid-stream with five words stored
        ia.en = 1'b1; ia.out_ready = 1'b0;
        repeat (5) begin
            ia.taus0 = $urandom;
            @(negedge clk);
        end
        chk("mid.level5", 32'(ia.level), 32'd5);
        #2 rst_a = 1'b0;
        #1;
        chk("mid.valid", 32'(ia.out_valid), 32'd0);
        chk("mid.level", 32'(ia.level), 32'd0);
        chk("mid.warm",  32'(ia.warm_done), 32'd0);
        @(negedge clk);
        rst_a = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("rewarm.e%0d", k), 32'(ia.warm_done), 32'(k >= 4));
        end

        // WARMUP=0 and decimation by 3 on instance b; taus0 = enabled-cycle index
        ia.en = 1'b0;
        idx = 0;
        got.delete();
        ib.out_ready = 1'b1;
        rst_b = 1'b1;
        for (int c = 0; c < 20; c++) begin
            ib.en = pat[c];
            ib.taus0 = 32'(idx);
            @(negedge clk);
            if (c == 0) begin
                chk("w0.warm_e1",  32'(ib.warm_done), 32'd1);
                chk("w0.valid_e1", 32'(ib.out_valid), 32'd1);
                chk("w0.data_e1",  ib.out_data, 32'd0);
            end
            if (pat[c]) idx++;
            if (ib.out_valid) got.push_back(ib.out_data);
        end
        chk("dec.count", 32'(got.size()), 32'((idx + 2) / 3));
        foreach (got[j])
            chk($sformatf("dec.val%0d", j), got[j], 32'(3 * j));

        // Random traffic on both instances against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(499) == 0) begin
                #2 rst_a = 1'b0;
                @(negedge clk);
                rst_a = 1'b1;
            end
            if ($urandom_range(499) == 0) begin
                #2 rst_b = 1'b0;
                @(negedge clk);
                rst_b = 1'b1;
            end
            ia.en = ($urandom_range(3) != 0);
            ib.en = ($urandom_range(3) != 0);
            ia.out_ready = (c < 1500) ? ($urandom_range(3) == 0) : 1'($urandom_range(1));
            ib.out_ready = (c < 1500) ? ($urandom_range(5) == 0) : 1'($urandom_range(1));
            ia.taus0 = $urandom; ia.taus1 = $urandom; ia.taus2 = $urandom;
            ib.taus0 = $urandom; ib.taus1 = $urandom; ib.taus2 = $urandom;
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
